irb_arb: RTL and testbench
==========================

IRB_ARB -- requirements
Module: irb_arb

Interface
REQ-001 Parameter WR_BURST, default 4, sets the maximum consecutive writer grants while the reader waits (legal range 1..15).
REQ-002 Parameter AW, default 6, is the IRB address width (64 pixels, 8x8 image).
REQ-003 Parameter DW, default 8, is the pixel data width.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_req  input  1  writer (LCD_CTRL write-back) requests one IRB write.
REQ-007 wr_addr  input  AW  writer target address.
REQ-008 wr_data  input  DW  writer pixel data.
REQ-009 wr_gnt  output  1  writer transaction accepted this cycle.
REQ-010 rd_req  input  1  reader (display scan) requests one IRB read.
REQ-011 rd_addr  input  AW  reader source address.
REQ-012 rd_gnt  output  1  reader transaction accepted this cycle.
REQ-013 rd_valid  output  1  rd_data valid, exactly one cycle per accepted read.
REQ-014 rd_data  output  DW  read pixel.
REQ-015 IRB_CEN  output  1  IRB chip enable, active-low.
REQ-016 IRB_RW  output  1  IRB write enable: 0 = write, 1 = read.
REQ-017 IRB_A  output  AW  IRB address.
REQ-018 IRB_D  output  DW  IRB write data.
REQ-019 IRB_Q  input  DW  IRB read data, valid one cycle after a read is sampled.

Function
REQ-020 Handshake: requester holds req, addr and data stable until it sees gnt; the transaction completes on the rising edge where req and gnt are both high.
REQ-021 wr_gnt and rd_gnt are combinational from req and arbiter state; they are never high together.
REQ-022 Idle (no gnt): IRB_CEN=1, IRB_RW=1, IRB_A and IRB_D hold their last values.
REQ-023 Write grant: IRB_CEN=0, IRB_RW=0, IRB_A=wr_addr, IRB_D=wr_data in the same cycle.
REQ-024 Read grant: IRB_CEN=0, IRB_RW=1, IRB_A=rd_addr; the next cycle rd_valid=1 and rd_data=IRB_Q, registered, so read latency is 2 edges from grant.
REQ-025 Only one requester active: it is granted every cycle (back-to-back, throughput 1/cycle).
REQ-026 Both active: writer has priority; burst counter bcnt increments on each writer grant while rd_req=1.
REQ-027 When bcnt==WR_BURST and both request, reader gets exactly one grant, then bcnt clears to 0.
REQ-028 bcnt clears to 0 on any cycle rd_req=0, and on any reader grant.
REQ-029 Reader starvation bound: with rd_req held, rd_gnt within WR_BURST+1 cycles.
REQ-030 Ordering: operations reach IRB in grant order; a read granted after a write to the same address returns the new data.
REQ-031 FSM states: IDLE (no gnt), WR (writer granted), RD (reader granted); next state is evaluated every cycle from req and bcnt, with no wait states.
REQ-032 rd_valid clears the cycle after assertion unless another read was granted the previous cycle.

Reset
REQ-033 On reset: wr_gnt=0, rd_gnt=0, rd_valid=0, rd_data=0, IRB_CEN=1, IRB_RW=1, IRB_A=0, IRB_D=0, bcnt=0, FSM=IDLE.
REQ-034 Grants are forced 0 while reset=1 regardless of req.
REQ-035 Reset mid-read cancels the pending rd_valid; no rd_valid is emitted after reset deasserts for a read granted before it.

Structure
REQ-036 Shared package holds the FSM state enum (IDLE/WR/RD), the IRB_WRITE=0 / IRB_READ=1 constants, and the AW/DW defaults shared with LCD_CTRL.
REQ-037 Single module; the grant/burst logic may be one sub-module irb_arb_pick (combinational grant plus bcnt register).

Verification
REQ-038 Writer only, wr_req held 64 cycles with addr 0..63, data=addr -> 64 consecutive wr_gnt; IRB mem[k]==k.
REQ-039 Reader only after V1, rd_addr 5 -> rd_gnt same cycle, rd_valid=1 with rd_data=0x05 two edges later.
REQ-040 Both held continuously, WR_BURST=4 -> grant pattern W W W W R W W W W R ...; no cycle with both gnts.
REQ-041 Write 0xAA to addr 9, then read addr 9 on the next grant -> rd_data=0xAA.
REQ-042 Reset asserted the cycle after a read grant -> no rd_valid; all outputs at reset values the next cycle.
REQ-043 wr_req and rd_req both low -> IRB_CEN=1, IRB_RW=1, no grants, bcnt=0.

Source files
------------

// File: rtl/irb_arb_pkg.sv
// Shared IRB definitions: arbiter state encoding, IRB access codes, default geometry.
package irb_arb_pkg;

   localparam int unsigned IRB_AW       = 6;   // 64 pixels, 8x8 image
   localparam int unsigned IRB_DW       = 8;
   localparam int unsigned IRB_WR_BURST = 4;

   localparam logic IRB_WRITE = 1'b0;
   localparam logic IRB_READ  = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WR   = 2'd1,
      ST_RD   = 2'd2
   } state_e;

endpackage

// File: rtl/irb_arb_if.sv
// Writer/reader handshakes plus the IRB memory pins, as seen by the arbiter (slave)
// and by the surrounding requesters/memory (master).
interface irb_arb_if
   import irb_arb_pkg::*;
#(
   parameter int unsigned AW = IRB_AW,
   parameter int unsigned DW = IRB_DW
);
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_gnt;
   logic          rd_req;
   logic [AW-1:0] rd_addr;
   logic          rd_gnt;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic          IRB_CEN;
   logic          IRB_RW;
   logic [AW-1:0] IRB_A;
   logic [DW-1:0] IRB_D;
   logic [DW-1:0] IRB_Q;

   modport slave (
      input  wr_req, wr_addr, wr_data, rd_req, rd_addr, IRB_Q,
      output wr_gnt, rd_gnt, rd_valid, rd_data, IRB_CEN, IRB_RW, IRB_A, IRB_D
   );

   modport master (
      output wr_req, wr_addr, wr_data, rd_req, rd_addr, IRB_Q,
      input  wr_gnt, rd_gnt, rd_valid, rd_data, IRB_CEN, IRB_RW, IRB_A, IRB_D
   );
endinterface

// File: rtl/irb_arb_pick.sv
// Grant selection with writer priority, bounded by a writer burst counter so the
// reader is served at least once every WR_BURST+1 cycles.
module irb_arb_pick
   import irb_arb_pkg::*;
#(
   parameter int unsigned WR_BURST = IRB_WR_BURST
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   i_wr_req,
   input  logic   i_rd_req,
   output state_e o_state_nxt
);
   localparam int unsigned BCW = $clog2(WR_BURST + 1);

   logic [BCW-1:0] r_bcnt;
   logic           w_burst_done;
   state_e         w_sel;

   // Writer has used up its burst allowance while the reader waits
   always_comb begin
      w_burst_done = (r_bcnt == BCW'(WR_BURST));
   end

   // Next-state decision: reset forces no grant, writer wins unless its burst is spent
   always_comb begin
      w_sel = ST_IDLE;
      if (!reset) begin
         if (i_wr_req && !(i_rd_req && w_burst_done)) begin
            w_sel = ST_WR;
         end else if (i_rd_req) begin
            w_sel = ST_RD;
         end
      end
   end

   // Burst counter: counts writer grants only while the reader is kept waiting
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bcnt <= '0;
      end else if (!i_rd_req || (w_sel == ST_RD)) begin
         r_bcnt <= '0;
      end else if (w_sel == ST_WR) begin
         r_bcnt <= r_bcnt + BCW'(1);
      end
   end

   assign o_state_nxt = w_sel;

endmodule

// File: rtl/irb_arb.sv
// Two-port arbiter in front of the single-ported IRB: writer (LCD_CTRL write-back)
// and reader (display scan) share the memory with same-cycle grants.
module irb_arb
   import irb_arb_pkg::*;
#(
   parameter int unsigned WR_BURST = IRB_WR_BURST,
   parameter int unsigned AW       = IRB_AW,
   parameter int unsigned DW       = IRB_DW
) (
   input  logic     clk,
   input  logic     reset,
   irb_arb_if.slave bus
);
   state_e        w_state_nxt;
   state_e        r_state;
   logic          w_wr_gnt;
   logic          w_rd_gnt;
   logic          w_cen;
   logic          w_rw;
   logic [AW-1:0] w_a;
   logic [DW-1:0] w_d;
   logic [AW-1:0] r_irb_a;
   logic [DW-1:0] r_irb_d;
   logic          r_rd_valid;
   logic [DW-1:0] r_rd_data;

   irb_arb_pick #(
      .WR_BURST (WR_BURST)
   ) u_pick (
      .clk         (clk),
      .reset       (reset),
      .i_wr_req    (bus.wr_req),
      .i_rd_req    (bus.rd_req),
      .o_state_nxt (w_state_nxt)
   );

   // State register: remembers which access was issued to the IRB last cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Output decode: grants and IRB pins follow the current selection; idle holds A/D
   always_comb begin
      w_wr_gnt = 1'b0;
      w_rd_gnt = 1'b0;
      w_cen    = 1'b1;
      w_rw     = IRB_READ;
      w_a      = r_irb_a;
      w_d      = r_irb_d;
      case (w_state_nxt)
         ST_WR: begin
            w_wr_gnt = 1'b1;
            w_cen    = 1'b0;
            w_rw     = IRB_WRITE;
            w_a      = bus.wr_addr;
            w_d      = bus.wr_data;
         end
         ST_RD: begin
            w_rd_gnt = 1'b1;
            w_cen    = 1'b0;
            w_rw     = IRB_READ;
            w_a      = bus.rd_addr;
         end
         default: ;
      endcase
   end

   // Last driven address/data, so the IRB pins stay quiet between accesses
   always_ff @(posedge clk) begin
      if (reset) begin
         r_irb_a <= '0;
         r_irb_d <= '0;
      end else begin
         if (!w_cen) begin
            r_irb_a <= w_a;
         end
         if (w_wr_gnt) begin
            r_irb_d <= w_d;
         end
      end
   end

   // Read return: IRB_Q is valid the cycle after a read was issued; capture it then
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= (r_state == ST_RD);
         if (r_state == ST_RD) begin
            r_rd_data <= bus.IRB_Q;
         end
      end
   end

   assign bus.wr_gnt   = w_wr_gnt;
   assign bus.rd_gnt   = w_rd_gnt;
   assign bus.IRB_CEN  = w_cen;
   assign bus.IRB_RW   = w_rw;
   assign bus.IRB_A    = w_a;
   assign bus.IRB_D    = w_d;
   assign bus.rd_valid = r_rd_valid;
   assign bus.rd_data  = r_rd_data;

endmodule

// File: tb/tb_irb_arb.sv
// Directed bench for irb_arb with a synchronous IRB memory model.
module tb_irb_arb;
   import irb_arb_pkg::*;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   logic [7:0] mem [64];

   irb_arb_if #(.AW(6), .DW(8)) bus ();

   irb_arb #(
      .WR_BURST (4),
      .AW       (6),
      .DW       (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // IRB model: write on CEN=0/RW=0, read data appears after the sampling edge
   always @(posedge clk) begin
      if (bus.IRB_CEN == 1'b0) begin
         if (bus.IRB_RW == 1'b0) mem[bus.IRB_A] <= bus.IRB_D;
         else                    bus.IRB_Q      <= mem[bus.IRB_A];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   typedef struct {
      logic       wr;
      logic [5:0] wa;
      logic [7:0] wd;
      logic       rd;
      logic [5:0] ra;
      logic       wg;
      logic       rg;
      logic       cen;
      logic       rw;
      logic [5:0] a;
      logic [7:0] d;
      logic       rv;
      logic [7:0] rdat;
      logic [2:0] bc;
   } vec_t;

   localparam int NV = 18;
   vec_t tv [NV];

   function automatic vec_t mk(logic wr, logic [5:0] wa, logic [7:0] wd, logic rd, logic [5:0] ra,
                               logic wg, logic rg, logic cen, logic rw, logic [5:0] a, logic [7:0] d,
                               logic rv, logic [7:0] rdat, logic [2:0] bc);
      vec_t v;
      v.wr = wr; v.wa = wa; v.wd = wd; v.rd = rd; v.ra = ra;
      v.wg = wg; v.rg = rg; v.cen = cen; v.rw = rw; v.a = a; v.d = d;
      v.rv = rv; v.rdat = rdat; v.bc = bc;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic wr, input logic [5:0] wa, input logic [7:0] wd,
                        input logic rd, input logic [5:0] ra);
      @(negedge clk);
      reset       = rst;
      bus.wr_req  = wr;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      bus.rd_req  = rd;
      bus.rd_addr = ra;
      #1;
   endtask

   initial begin
      int bad;
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      bus.IRB_Q   = 8'h00;
      reset       = 1'b1;
      bus.wr_req  = 1'b1;
      bus.wr_addr = 6'd1;
      bus.wr_data = 8'h11;
      bus.rd_req  = 1'b1;
      bus.rd_addr = 6'd2;

      // Reset values, grants forced low even with both requests up
      drive(1'b1, 1'b1, 6'd1, 8'h11, 1'b1, 6'd2);
      chk("rst wr_gnt",   32'(bus.wr_gnt),   32'd0);
      chk("rst rd_gnt",   32'(bus.rd_gnt),   32'd0);
      chk("rst rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst rd_data",  32'(bus.rd_data),  32'd0);
      chk("rst IRB_CEN",  32'(bus.IRB_CEN),  32'd1);
      chk("rst IRB_RW",   32'(bus.IRB_RW),   32'd1);
      chk("rst IRB_A",    32'(bus.IRB_A),    32'd0);
      chk("rst IRB_D",    32'(bus.IRB_D),    32'd0);
      chk("rst bcnt",     32'(dut.u_pick.r_bcnt), 32'd0);

      // Writer only: 64 back-to-back writes, data = address
      for (int k = 0; k < 64; k++) begin
         drive(1'b0, 1'b1, 6'(k), 8'(k), 1'b0, 6'd0);
         chk($sformatf("v1 wr_gnt k=%0d", k), 32'(bus.wr_gnt), 32'd1);
         chk($sformatf("v1 rd_gnt k=%0d", k), 32'(bus.rd_gnt), 32'd0);
         chk($sformatf("v1 pins k=%0d", k),
             32'({bus.IRB_CEN, bus.IRB_RW, bus.IRB_A, bus.IRB_D}), 32'({1'b0, 1'b0, 6'(k), 8'(k)}));
      end
      drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 6'd0);
      bad = 0;
      for (int k = 0; k < 64; k++) if (mem[k] !== 8'(k)) bad++;
      chk("v1 mem contents bad count", 32'(bad), 32'd0);

      // Directed single-cycle vectors
      tv[0]  = mk(0, 0,  8'h00, 0, 0, 0, 0, 1, 1, 63, 8'h3F, 0, 8'h00, 0);
      tv[1]  = mk(0, 0,  8'h00, 1, 5, 0, 1, 0, 1, 5,  8'h3F, 0, 8'h00, 0);
      tv[2]  = mk(0, 0,  8'h00, 0, 0, 0, 0, 1, 1, 5,  8'h3F, 0, 8'h00, 0);
      tv[3]  = mk(0, 0,  8'h00, 0, 0, 0, 0, 1, 1, 5,  8'h3F, 1, 8'h05, 0);
      tv[4]  = mk(1, 9,  8'hAA, 0, 0, 1, 0, 0, 0, 9,  8'hAA, 0, 8'h05, 0);
      tv[5]  = mk(0, 0,  8'h00, 1, 9, 0, 1, 0, 1, 9,  8'hAA, 0, 8'h05, 0);
      tv[6]  = mk(0, 0,  8'h00, 1, 5, 0, 1, 0, 1, 5,  8'hAA, 0, 8'h05, 0);
      tv[7]  = mk(0, 0,  8'h00, 0, 0, 0, 0, 1, 1, 5,  8'hAA, 1, 8'hAA, 0);
      tv[8]  = mk(0, 0,  8'h00, 0, 0, 0, 0, 1, 1, 5,  8'hAA, 1, 8'h05, 0);
      tv[9]  = mk(0, 0,  8'h00, 0, 0, 0, 0, 1, 1, 5,  8'hAA, 0, 8'h05, 0);
      tv[10] = mk(1, 20, 8'h33, 1, 9, 1, 0, 0, 0, 20, 8'h33, 0, 8'h05, 0);
      tv[11] = mk(1, 20, 8'h33, 1, 9, 1, 0, 0, 0, 20, 8'h33, 0, 8'h05, 1);
      tv[12] = mk(1, 20, 8'h33, 1, 9, 1, 0, 0, 0, 20, 8'h33, 0, 8'h05, 2);
      tv[13] = mk(1, 20, 8'h33, 1, 9, 1, 0, 0, 0, 20, 8'h33, 0, 8'h05, 3);
      tv[14] = mk(1, 20, 8'h33, 1, 9, 0, 1, 0, 1, 9,  8'h33, 0, 8'h05, 4);
      tv[15] = mk(1, 20, 8'h33, 1, 9, 1, 0, 0, 0, 20, 8'h33, 0, 8'h05, 0);
      tv[16] = mk(0, 0,  8'h00, 0, 0, 0, 0, 1, 1, 20, 8'h33, 1, 8'hAA, 1);
      tv[17] = mk(0, 0,  8'h00, 0, 0, 0, 0, 1, 1, 20, 8'h33, 0, 8'hAA, 0);

      for (int i = 0; i < NV; i++) begin
         drive(1'b0, tv[i].wr, tv[i].wa, tv[i].wd, tv[i].rd, tv[i].ra);
         chk($sformatf("v%0d wr_gnt", i),   32'(bus.wr_gnt),   32'(tv[i].wg));
         chk($sformatf("v%0d rd_gnt", i),   32'(bus.rd_gnt),   32'(tv[i].rg));
         chk($sformatf("v%0d IRB_CEN", i),  32'(bus.IRB_CEN),  32'(tv[i].cen));
         chk($sformatf("v%0d IRB_RW", i),   32'(bus.IRB_RW),   32'(tv[i].rw));
         chk($sformatf("v%0d IRB_A", i),    32'(bus.IRB_A),    32'(tv[i].a));
         chk($sformatf("v%0d IRB_D", i),    32'(bus.IRB_D),    32'(tv[i].d));
         chk($sformatf("v%0d rd_valid", i), 32'(bus.rd_valid), 32'(tv[i].rv));
         chk($sformatf("v%0d rd_data", i),  32'(bus.rd_data),  32'(tv[i].rdat));
         chk($sformatf("v%0d bcnt", i),     32'(dut.u_pick.r_bcnt), 32'(tv[i].bc));
      end

      // Both held continuously: W W W W R repeating, never both granted
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b1, 6'd30, 8'h11, 1'b1, 6'd63);
         chk($sformatf("burst rd_gnt i=%0d", i), 32'(bus.rd_gnt), 32'((i % 5) == 4));
         chk($sformatf("burst wr_gnt i=%0d", i), 32'(bus.wr_gnt), 32'((i % 5) != 4));
      end

      // Reset the cycle after a read grant cancels its rd_valid
      drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 6'd0);
      drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, 6'd5);
      chk("rstrd rd_gnt", 32'(bus.rd_gnt), 32'd1);
      drive(1'b1, 1'b1, 6'd7, 8'h77, 1'b1, 6'd5);
      chk("rstrd forced gnts", 32'({bus.wr_gnt, bus.rd_gnt}), 32'd0);
      chk("rstrd forced cen",  32'(bus.IRB_CEN), 32'd1);
      drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 6'd0);
      chk("rstrd rd_valid",  32'(bus.rd_valid), 32'd0);
      chk("rstrd rd_data",   32'(bus.rd_data),  32'd0);
      chk("rstrd cen/rw",    32'({bus.IRB_CEN, bus.IRB_RW}), 32'd3);
      chk("rstrd IRB_A",     32'(bus.IRB_A), 32'd0);
      chk("rstrd IRB_D",     32'(bus.IRB_D), 32'd0);
      chk("rstrd gnts",      32'({bus.wr_gnt, bus.rd_gnt}), 32'd0);
      chk("rstrd bcnt",      32'(dut.u_pick.r_bcnt), 32'd0);
      drive(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 6'd0);
      chk("rstrd rd_valid later", 32'(bus.rd_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
